// File: rtl/nonlinear_job_scheduler.sv
// Job scheduler for the nonlinear/pooling unit: descriptor FIFO plus a launch/run/done FSM.
// Optional RUN watchdog enabled by defining NL_SCHED_TIMEOUT_EN.
module nonlinear_job_scheduler #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [1:0]  job_type,
  input  logic [15:0] job_cycles,
  input  logic [15:0] job_padded_cx,
  input  logic [7:0]  job_shift,
  output logic        nl_enable,
  input  logic        nl_finished,
  output logic [1:0]  nl_type,
  output logic [15:0] nl_cycles,
  output logic [15:0] nl_padded_cx,
  output logic [7:0]  nl_shift,
  output logic        busy,
  output logic        done_pulse,
  output logic [15:0] jobs_completed,
  output logic        error,
  output logic        timeout_flag,
  input  logic        error_clr
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned DW = 42;

  generate
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("FIFO_DEPTH must be a power of two, at least 2");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be in 1..65535");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_LAUNCH, S_RUN, S_DONE, S_COOLDOWN, S_HALT
  } state_t;

  state_t r_state, w_next;

  logic [DW-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]   r_wr_ptr, r_rd_ptr;
  logic [DW-1:0] w_head;
  logic          w_empty, w_full, w_push, w_pop;

  logic [1:0]  r_nl_type;
  logic [15:0] r_nl_cycles, r_nl_padded_cx;
  logic [7:0]  r_nl_shift;
  logic [15:0] r_jobs;
  logic        r_error, r_run_first;
  logic        w_job_bad, w_chk_fail, w_fin_ok, w_wdog_trip, w_err_set;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push  = job_valid && !w_full;
  assign w_pop   = (r_state == S_IDLE) && !w_empty;
  assign w_head  = r_mem[r_rd_ptr[AW-1:0]];
  assign job_ready = !w_full;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= {job_type, job_cycles, job_padded_cx, job_shift};
  end

  assign w_job_bad  = !((r_nl_type == 2'd1) || (r_nl_type == 2'd2)) || (r_nl_cycles == '0);
  assign w_chk_fail = (r_state == S_CHECK) && w_job_bad;
  assign w_fin_ok   = !r_run_first && nl_finished;

`ifdef NL_SCHED_TIMEOUT_EN
  localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] r_wdog;
  logic        r_timeout;

  // A finish sampled on the same cycle as the last watchdog count still completes the job.
  assign w_wdog_trip = (r_state == S_RUN) && !w_fin_ok && (r_wdog == WDOG_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wdog    <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (r_state == S_LAUNCH)   r_wdog <= '0;
      else if (r_state == S_RUN) r_wdog <= r_wdog + 16'd1;
      if (w_wdog_trip)    r_timeout <= 1'b1;
      else if (error_clr) r_timeout <= 1'b0;
    end
  end
  assign timeout_flag = r_timeout;
`else
  assign w_wdog_trip  = 1'b0;
  assign timeout_flag = 1'b0;
`endif

  assign w_err_set = w_chk_fail || w_wdog_trip;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= S_IDLE;
      r_nl_type      <= '0;
      r_nl_cycles    <= '0;
      r_nl_padded_cx <= '0;
      r_nl_shift     <= '0;
      r_jobs         <= '0;
      r_error        <= 1'b0;
      r_run_first    <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_run_first <= (r_state == S_LAUNCH);
      if (w_pop) {r_nl_type, r_nl_cycles, r_nl_padded_cx, r_nl_shift} <= w_head;
      if (r_state == S_DONE) r_jobs <= r_jobs + 16'd1;
      if (w_err_set)      r_error <= 1'b1;
      else if (error_clr) r_error <= 1'b0;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (!w_empty) w_next = S_CHECK;
      S_CHECK:    w_next = w_job_bad ? S_IDLE : S_LAUNCH;
      S_LAUNCH:   w_next = S_RUN;
      S_RUN: begin
        if (w_fin_ok)         w_next = S_DONE;
        else if (w_wdog_trip) w_next = S_HALT;
      end
      S_DONE:     w_next = S_COOLDOWN;
      S_COOLDOWN: w_next = S_IDLE;
      S_HALT:     if (error_clr) w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_comb begin
    nl_enable  = (r_state == S_LAUNCH);
    done_pulse = (r_state == S_DONE);
    busy       = (r_state != S_IDLE);
  end

  assign nl_type        = r_nl_type;
  assign nl_cycles      = r_nl_cycles;
  assign nl_padded_cx   = r_nl_padded_cx;
  assign nl_shift       = r_nl_shift;
  assign jobs_completed = r_jobs;
  assign error          = r_error;

endmodule

// File: tb/tb_nonlinear_job_scheduler.sv
// Directed bench for nonlinear_job_scheduler with hand-computed expectations.
// Define NL_SCHED_TIMEOUT_EN to also exercise the watchdog path.
module tb_nonlinear_job_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        job_valid, job_ready;
  logic [1:0]  job_type;
  logic [15:0] job_cycles, job_padded_cx;
  logic [7:0]  job_shift;
  logic        nl_enable, nl_finished;
  logic [1:0]  nl_type;
  logic [15:0] nl_cycles, nl_padded_cx;
  logic [7:0]  nl_shift;
  logic        busy, done_pulse, error, timeout_flag, error_clr;
  logic [15:0] jobs_completed;

  int n_checks = 0;
  int n_pass   = 0;
  int n_en     = 0;
  int n_done   = 0;
  int en_double = 0;
  logic prev_en = 1'b0;
  logic [15:0] launch_q [$];

  nonlinear_job_scheduler #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .reset(reset),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_type(job_type), .job_cycles(job_cycles),
    .job_padded_cx(job_padded_cx), .job_shift(job_shift),
    .nl_enable(nl_enable), .nl_finished(nl_finished),
    .nl_type(nl_type), .nl_cycles(nl_cycles),
    .nl_padded_cx(nl_padded_cx), .nl_shift(nl_shift),
    .busy(busy), .done_pulse(done_pulse), .jobs_completed(jobs_completed),
    .error(error), .timeout_flag(timeout_flag), .error_clr(error_clr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset) begin
      prev_en = 1'b0;
    end else begin
      if (nl_enable) begin
        launch_q.push_back(nl_cycles);
        n_en++;
        if (prev_en) en_double++;
      end
      prev_en = nl_enable;
      if (done_pulse) n_done++;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_enable(input string tag);
    int b = 0;
    while (!nl_enable && b < 20) begin tick(); b++; end
    check(tag, b < 20, 1);
  endtask

  initial begin
    int b;
    int snap_en, snap_done;
    logic [15:0] exp_order [6];
    exp_order[0] = 16'd9;  exp_order[1] = 16'd10; exp_order[2] = 16'd11;
    exp_order[3] = 16'd12; exp_order[4] = 16'd13; exp_order[5] = 16'd14;

    reset = 1'b0; job_valid = 1'b0; job_type = '0; job_cycles = '0;
    job_padded_cx = '0; job_shift = '0; nl_finished = 1'b0; error_clr = 1'b0;

    // Reset values
    #12;
    check("rst_flags", {busy, done_pulse, nl_enable, error, timeout_flag, job_ready}, 6'b000001);
    check("rst_jobs", jobs_completed, 0);
    check("rst_cfg", {nl_type, nl_cycles, nl_padded_cx, nl_shift}, 0);
    tick();
    reset = 1'b1;
    tick();

    // Single job: latency and done handshake, finish held early
    job_valid = 1'b1; job_type = 2'd1; job_cycles = 16'd64;
    job_padded_cx = 16'h0123; job_shift = 8'h05;
    check("t1_ready", job_ready, 1);
    tick();
    job_valid = 1'b0;
    check("t1_n1_en", nl_enable, 0);
    tick();
    check("t1_n2_busy", busy, 1);
    check("t1_cfg", {nl_type, nl_cycles, nl_padded_cx, nl_shift}, {2'd1, 16'd64, 16'h0123, 8'h05});
    nl_finished = 1'b1;
    tick();
    check("t1_n3_en", nl_enable, 1);
    tick();
    check("t1_run1", {nl_enable, done_pulse}, 2'b00);
    tick();
    check("t1_run2_done", done_pulse, 0);
    tick();
    check("t1_done", done_pulse, 1);
    tick();
    check("t1_cool", {done_pulse, busy}, 2'b01);
    check("t1_jobs", jobs_completed, 1);
    tick();
    check("t1_idle_busy", busy, 0);
    check("t1_retain", nl_cycles, 64);
    nl_finished = 1'b0;

    // Backpressure and FIFO order with the unit stalled
    launch_q.delete();
    job_valid = 1'b1; job_type = 2'd2; job_cycles = 16'd9;
    tick();
    job_valid = 1'b0;
    wait_enable("t2_x_launch");
    tick();
    for (int i = 0; i < 4; i++) begin
      job_valid = 1'b1; job_type = 2'd1; job_cycles = 16'(10 + i);
      tick();
    end
    check("t2_full", job_ready, 0);
    job_cycles = 16'd14;
    tick();
    check("t2_still_full", job_ready, 0);
    nl_finished = 1'b1;
    b = 0;
    while (!job_ready && b < 100) begin tick(); b++; end
    check("t2_ready_return", b < 100, 1);
    tick();
    job_valid = 1'b0;
    b = 0;
    while (!(jobs_completed == 16'd7 && !busy) && b < 200) begin tick(); b++; end
    check("t2_drain", b < 200, 1);
    check("t2_nlaunch", launch_q.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < launch_q.size()) check($sformatf("t2_order%0d", i), launch_q[i], exp_order[i]);
    check("t2_en_single", en_double, 0);
    check("t2_ndone", n_done, 7);
    nl_finished = 1'b0;

    // Invalid descriptors are dropped with error
    snap_en = n_en;
    job_valid = 1'b1; job_type = 2'd3; job_cycles = 16'd5;
    tick();
    job_type = 2'd2; job_cycles = 16'd0;
    tick();
    job_valid = 1'b0;
    repeat (10) tick();
    check("t3_error", error, 1);
    check("t3_no_en", n_en, snap_en);
    check("t3_jobs", jobs_completed, 7);
    check("t3_idle", busy, 0);
    error_clr = 1'b1;
    tick();
    error_clr = 1'b0;
    check("t3_clr", error, 0);

    // New error beats a coincident clear
    job_valid = 1'b1; job_type = 2'd0; job_cycles = 16'd5;
    tick();
    job_valid = 1'b0;
    tick();
    check("t3_in_check", busy, 1);
    error_clr = 1'b1;
    tick();
    error_clr = 1'b0;
    check("t3_set_wins", error, 1);
    error_clr = 1'b1;
    tick();
    error_clr = 1'b0;
    check("t3_clr2", error, 0);

`ifdef NL_SCHED_TIMEOUT_EN
    // Watchdog trip into HALT, queued job held until clear
    job_valid = 1'b1; job_type = 2'd1; job_cycles = 16'd77;
    tick();
    job_cycles = 16'd88;
    tick();
    job_valid = 1'b0;
    wait_enable("t4_launch");
    check("t4_first", nl_cycles, 77);
    b = 0;
    while (!timeout_flag && b < 300) begin tick(); b++; end
    check("t4_run_len", b, 101);
    check("t4_halt", {error, busy}, 2'b11);
    snap_en = n_en;
    repeat (20) tick();
    check("t4_no_launch", n_en, snap_en);
    check("t4_ready", job_ready, 1);
    error_clr = 1'b1;
    tick();
    error_clr = 1'b0;
    check("t4_clr", {timeout_flag, error}, 2'b00);
    wait_enable("t4_relaunch");
    check("t4_second", nl_cycles, 88);
    nl_finished = 1'b1;
    b = 0;
    while (busy && b < 20) begin tick(); b++; end
    check("t4_finish", b < 20, 1);
    nl_finished = 1'b0;
    check("t4_jobs", jobs_completed, 8);
`endif

    // Reset mid-RUN with two jobs queued
    job_valid = 1'b1; job_type = 2'd1; job_cycles = 16'd1;
    tick();
    job_cycles = 16'd2;
    tick();
    job_cycles = 16'd3;
    tick();
    job_valid = 1'b0;
    wait_enable("t5_launch");
    tick();
    tick();
    check("t5_in_run", busy, 1);
    reset = 1'b0;
    #1;
    check("t5_rst_flags", {busy, done_pulse, nl_enable, error, timeout_flag, job_ready}, 6'b000001);
    check("t5_rst_jobs", jobs_completed, 0);
    check("t5_rst_cfg", {nl_type, nl_cycles, nl_padded_cx, nl_shift}, 0);
    snap_en = n_en;
    snap_done = n_done;
    tick();
    tick();
    reset = 1'b1;
    nl_finished = 1'b1;
    repeat (20) tick();
    check("t5_no_launch", n_en, snap_en);
    check("t5_no_done", n_done, snap_done);
    check("t5_after", {busy, job_ready, jobs_completed}, {1'b0, 1'b1, 16'd0});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
